// File: rtl/trace_pkg.sv
// Shared types for the commit-trace checker: event kinds, error codes,
// the buffered expected-event record and the checker state encoding.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } trace_kind_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_KIND     = 3'd1;
    localparam logic [2:0] ERR_DATA     = 3'd2;
    localparam logic [2:0] ERR_STARVED  = 3'd3;
    localparam logic [2:0] ERR_LEFTOVER = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    typedef struct packed {
        trace_kind_e kind;
        logic [15:0] a;
        logic [15:0] d;
    } trace_evt_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Expected-event FIFO: one push per cycle, pop of 0..4 entries per cycle,
// combinational peek of the four oldest entries (slots past count are stale).
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_evt_t               push_evt,
    input  logic [2:0]               pop_n,
    output trace_evt_t [3:0]         peek,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    trace_evt_t     mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_evt;
        end
    end

    // Pointer and occupancy update; push and multi-pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            head  <= head + AW'(pop_n);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_n);
        end
    end

    // Head window for in-order comparison against up to four observations.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            peek[i] = mem[head + AW'(i)];
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Golden-trace checker: compares live commit events against a buffered
// stream of expected events and latches the first failure.
// Optional build macro TRACE_CHK_CONTINUE_EN: data/kind mismatches are
// counted on err_count instead of stopping the check.
//
// state   | meaning
// ST_RUN  | accepting expected events, comparing observed commits
// ST_PASS | HALT matched with nothing left over (and no errors)
// ST_FAIL | terminal failure, err_* hold the first failure
module commit_trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [1:0]  exp_kind,
    input  logic [15:0] exp_a,
    input  logic [15:0] exp_d,
    input  logic        reg_we,
    input  logic [3:0]  reg_id,
    input  logic [15:0] reg_data,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_wdata,
    input  logic        halt,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [31:0] err_cycle,
    output logic [15:0] err_exp_a,
    output logic [15:0] err_exp_d,
    output logic [15:0] err_got_a,
    output logic [15:0] err_got_d,
`ifdef TRACE_CHK_CONTINUE_EN
    output logic [15:0] err_count,
`endif
    output logic [15:0] events_checked
);

    localparam int AW = $clog2(DEPTH);

    chk_state_e       state, state_nxt;
    logic [AW:0]      count;
    trace_evt_t [3:0] peek;
    trace_evt_t       push_evt;
    logic             push;
    logic [2:0]       pop_n;

    trace_kind_e      obs_kind [4];
    logic [15:0]      obs_a [4];
    logic [15:0]      obs_d [4];
    logic [2:0]       n_obs;

    logic             mis_any, halt_ok;
    logic [2:0]       mis_code, mis_n;
    logic [15:0]      mis_exp_a, mis_exp_d, mis_got_a, mis_got_d;

    logic [2:0]       new_err, add_ok;
    logic [31:0]      idle_cnt, idle_nxt, cycle_cnt;
    logic [16:0]      chk_sum;

    assign exp_ready = (state == ST_RUN) && (count < (AW+1)'(DEPTH));
    assign push      = exp_valid & exp_ready;
    assign push_evt  = '{kind: trace_kind_e'(exp_kind), a: exp_a, d: exp_d};
    assign done      = (state != ST_RUN);
    assign pass      = (state == ST_PASS);
    assign chk_sum   = {1'b0, events_checked} + 17'(add_ok);

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_evt (push_evt),
        .pop_n    (pop_n),
        .peek     (peek),
        .count    (count)
    );

    // Pack this cycle's commit signals into the fixed REG/LOAD/STORE/HALT order.
    always_comb begin
        n_obs = '0;
        for (int i = 0; i < 4; i++) begin
            obs_kind[i] = KIND_REG;
            obs_a[i]    = '0;
            obs_d[i]    = '0;
        end
        if (reg_we) begin
            obs_kind[n_obs[1:0]] = KIND_REG;
            obs_a[n_obs[1:0]]    = {12'd0, reg_id};
            obs_d[n_obs[1:0]]    = reg_data;
            n_obs = n_obs + 3'd1;
        end
        if (mem_re) begin
            obs_kind[n_obs[1:0]] = KIND_LOAD;
            obs_a[n_obs[1:0]]    = mem_addr;
            obs_d[n_obs[1:0]]    = mem_rdata;
            n_obs = n_obs + 3'd1;
        end
        if (mem_we) begin
            obs_kind[n_obs[1:0]] = KIND_STORE;
            obs_a[n_obs[1:0]]    = mem_addr;
            obs_d[n_obs[1:0]]    = mem_wdata;
            n_obs = n_obs + 3'd1;
        end
        if (halt) begin
            obs_kind[n_obs[1:0]] = KIND_HALT;
            n_obs = n_obs + 3'd1;
        end
    end

    // Compare observations against the FIFO head window; keep the lowest-index miss.
    always_comb begin
        logic bad_kind;
        logic bad_data;
        mis_any   = 1'b0;
        mis_code  = ERR_NONE;
        mis_n     = '0;
        halt_ok   = 1'b0;
        mis_exp_a = '0;
        mis_exp_d = '0;
        mis_got_a = '0;
        mis_got_d = '0;
        for (int i = 0; i < 4; i++) begin
            bad_kind = 1'b0;
            bad_data = 1'b0;
            if (3'(i) < n_obs) begin
                bad_kind = (peek[i].kind != obs_kind[i]);
                if (!bad_kind) begin
                    case (obs_kind[i])
                        KIND_REG:  bad_data = (peek[i].a[3:0] != obs_a[i][3:0]) || (peek[i].d != obs_d[i]);
                        KIND_HALT: bad_data = 1'b0;
                        default:   bad_data = (peek[i].a != obs_a[i]) || (peek[i].d != obs_d[i]);
                    endcase
                end
                if (bad_kind || bad_data) begin
                    mis_n = mis_n + 3'd1;
                    if (!mis_any) begin
                        mis_any   = 1'b1;
                        mis_code  = bad_kind ? ERR_KIND : ERR_DATA;
                        mis_exp_a = peek[i].a;
                        mis_exp_d = peek[i].d;
                        mis_got_a = bad_kind ? 16'd0 : obs_a[i];
                        mis_got_d = bad_kind ? 16'd0 : obs_d[i];
                    end
                end else if (obs_kind[i] == KIND_HALT) begin
                    halt_ok = 1'b1;
                end
            end
        end
    end

`ifdef TRACE_CHK_CONTINUE_EN
    logic [2:0]  add_err;
    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_count} + 17'(add_err);
`endif

    // Next state, pop amount and the failure (if any) raised this cycle.
    always_comb begin
        state_nxt = state;
        pop_n     = '0;
        add_ok    = '0;
        new_err   = ERR_NONE;
        idle_nxt  = idle_cnt;
`ifdef TRACE_CHK_CONTINUE_EN
        add_err   = '0;
`endif
        if (state == ST_RUN) begin
            if (n_obs != 3'd0) begin
                idle_nxt = '0;
            end else if (idle_cnt != '1) begin
                idle_nxt = idle_cnt + 32'd1;
            end
            if ((AW+1)'(n_obs) > count) begin
                new_err   = ERR_STARVED;
                state_nxt = ST_FAIL;
            end else if (n_obs != 3'd0) begin
`ifdef TRACE_CHK_CONTINUE_EN
                pop_n   = n_obs;
                add_ok  = n_obs - mis_n;
                add_err = mis_n;
                if (mis_any) begin
                    new_err = mis_code;
                end
                if (halt_ok) begin
                    if (count != (AW+1)'(n_obs)) begin
                        state_nxt = ST_FAIL;
                        if (!mis_any) begin
                            new_err = ERR_LEFTOVER;
                        end
                    end else if (err_count == 16'd0 && !mis_any) begin
                        state_nxt = ST_PASS;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
`else
                if (mis_any) begin
                    new_err   = mis_code;
                    state_nxt = ST_FAIL;
                end else begin
                    pop_n  = n_obs;
                    add_ok = n_obs - mis_n;
                    if (halt_ok) begin
                        if (count != (AW+1)'(n_obs)) begin
                            new_err   = ERR_LEFTOVER;
                            state_nxt = ST_FAIL;
                        end else begin
                            state_nxt = ST_PASS;
                        end
                    end
                end
`endif
            end else if (TIMEOUT != 0 && idle_nxt == 32'(TIMEOUT)) begin
                new_err   = ERR_TIMEOUT;
                state_nxt = ST_FAIL;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN-cycle, idle and matched-event counters (all saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt      <= '0;
            idle_cnt       <= '0;
            events_checked <= '0;
        end else begin
            if (state == ST_RUN && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            idle_cnt       <= idle_nxt;
            events_checked <= chk_sum[16] ? 16'hFFFF : chk_sum[15:0];
        end
    end

    // Latch details of the first failure only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_code  <= ERR_NONE;
            err_cycle <= '0;
            err_exp_a <= '0;
            err_exp_d <= '0;
            err_got_a <= '0;
            err_got_d <= '0;
        end else if (new_err != ERR_NONE && err_code == ERR_NONE) begin
            err_code  <= new_err;
            err_cycle <= cycle_cnt;
            if (new_err == ERR_KIND || new_err == ERR_DATA) begin
                err_exp_a <= mis_exp_a;
                err_exp_d <= mis_exp_d;
                err_got_a <= mis_got_a;
                err_got_d <= mis_got_d;
            end
        end
    end

`ifdef TRACE_CHK_CONTINUE_EN
    // Mismatch tally for the keep-going build.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: directed scenarios plus randomized traces,
// all outputs checked every cycle against a queue-based reference model.
module tb_commit_trace_checker;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exp_valid = 1'b0;
    logic [1:0]  exp_kind = '0;
    logic [15:0] exp_a = '0, exp_d = '0;
    logic        reg_we = 1'b0;
    logic [3:0]  reg_id = '0;
    logic [15:0] reg_data = '0;
    logic        mem_re = 1'b0, mem_we = 1'b0;
    logic [15:0] mem_addr = '0, mem_rdata = '0, mem_wdata = '0;
    logic        halt = 1'b0;
    logic        exp_ready, done, pass;
    logic [2:0]  err_code;
    logic [31:0] err_cycle;
    logic [15:0] err_exp_a, err_exp_d, err_got_a, err_got_d, events_checked;
`ifdef TRACE_CHK_CONTINUE_EN
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_kind       (exp_kind),
        .exp_a          (exp_a),
        .exp_d          (exp_d),
        .reg_we         (reg_we),
        .reg_id         (reg_id),
        .reg_data       (reg_data),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_wdata      (mem_wdata),
        .halt           (halt),
        .done           (done),
        .pass           (pass),
        .err_code       (err_code),
        .err_cycle      (err_cycle),
        .err_exp_a      (err_exp_a),
        .err_exp_d      (err_exp_d),
        .err_got_a      (err_got_a),
        .err_got_d      (err_got_d),
`ifdef TRACE_CHK_CONTINUE_EN
        .err_count      (err_count),
`endif
        .events_checked (events_checked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: 0 running, 1 passed, 2 failed
    ev_t         q[$];
    int          m_st = 0;
    logic [2:0]  m_code = '0;
    logic [31:0] m_cycle = '0, m_ecyc = '0;
    int          m_idle = 0;
    logic [15:0] m_ea = '0, m_ed = '0, m_ga = '0, m_gd = '0;
    int          m_chk = 0;
    int          m_errs = 0;
    bit          m_pushed = 0;

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.k = k;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = 0; m_code = '0; m_cycle = '0; m_ecyc = '0; m_idle = 0;
        m_ea = '0; m_ed = '0; m_ga = '0; m_gd = '0; m_chk = 0; m_errs = 0;
    endtask

    task automatic record_err(input logic [2:0] code, input logic [15:0] ea, input logic [15:0] ed,
                              input logic [15:0] ga, input logic [15:0] gd);
        if (m_code == 3'd0) begin
            m_code = code; m_ecyc = m_cycle;
            m_ea = ea; m_ed = ed; m_ga = ga; m_gd = gd;
        end
    endtask

    task automatic check_all();
        chk("exp_ready", exp_ready, (m_st == 0) && (q.size() < DEPTH));
        chk("done", done, m_st != 0);
        chk("pass", pass, m_st == 1);
        chk("err_code", err_code, m_code);
        chk("err_cycle", err_cycle, m_ecyc);
        chk("err_exp_a", err_exp_a, m_ea);
        chk("err_exp_d", err_exp_d, m_ed);
        chk("err_got_a", err_got_a, m_ga);
        chk("err_got_d", err_got_d, m_gd);
        chk("events_checked", events_checked, m_chk);
`ifdef TRACE_CHK_CONTINUE_EN
        chk("err_count", err_count, m_errs);
`endif
    endtask

    // One clock: model the cycle from the currently driven inputs, clock, check.
    task automatic tick();
        ev_t obs[$];
        bit  ready;
        bit  halt_hit;
        int  nmis;
        int  first;
        ready    = (m_st == 0) && (q.size() < DEPTH);
        m_pushed = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_st == 0) begin
            if (reg_we) obs.push_back(mk(2'd0, {12'd0, reg_id}, reg_data));
            if (mem_re) obs.push_back(mk(2'd1, mem_addr, mem_rdata));
            if (mem_we) obs.push_back(mk(2'd2, mem_addr, mem_wdata));
            if (halt)   obs.push_back(mk(2'd3, 16'd0, 16'd0));
            if (obs.size() > 0) m_idle = 0; else m_idle++;
            if (obs.size() > q.size()) begin
                record_err(3'd3, 0, 0, 0, 0);
                m_st = 2;
            end else if (obs.size() > 0) begin
                nmis = 0; first = -1; halt_hit = 0;
                foreach (obs[i]) begin
                    bit kbad, dbad;
                    kbad = (obs[i].k != q[i].k);
                    dbad = !kbad && (obs[i].k != 2'd3) &&
                           ((obs[i].d != q[i].d) ||
                            ((obs[i].k == 2'd0) ? (obs[i].a[3:0] != q[i].a[3:0]) : (obs[i].a != q[i].a)));
                    if (kbad || dbad) begin
                        nmis++;
                        if (first < 0) begin
                            first = i;
                            record_err(kbad ? 3'd1 : 3'd2, q[i].a, q[i].d,
                                       kbad ? 16'd0 : obs[i].a, kbad ? 16'd0 : obs[i].d);
                        end
                    end else if (obs[i].k == 2'd3) begin
                        halt_hit = 1;
                    end
                end
`ifdef TRACE_CHK_CONTINUE_EN
                repeat (obs.size()) void'(q.pop_front());
                m_chk  = (m_chk + obs.size() - nmis > 65535) ? 65535 : m_chk + obs.size() - nmis;
                m_errs = (m_errs + nmis > 65535) ? 65535 : m_errs + nmis;
                if (halt_hit) begin
                    if (q.size() != 0) begin
                        record_err(3'd4, 0, 0, 0, 0);
                        m_st = 2;
                    end else begin
                        m_st = (m_errs == 0) ? 1 : 2;
                    end
                end
`else
                if (nmis > 0) begin
                    m_st = 2;
                end else begin
                    repeat (obs.size()) void'(q.pop_front());
                    m_chk = (m_chk + obs.size() > 65535) ? 65535 : m_chk + obs.size();
                    if (halt_hit) begin
                        if (q.size() == 0) m_st = 1;
                        else begin
                            record_err(3'd4, 0, 0, 0, 0);
                            m_st = 2;
                        end
                    end
                end
`endif
            end else if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
                record_err(3'd5, 0, 0, 0, 0);
                m_st = 2;
            end
            m_cycle = m_cycle + 32'd1;
            if (exp_valid && ready) begin
                q.push_back(mk(exp_kind, exp_a, exp_d));
                m_pushed = 1;
            end
        end
        @(posedge clk);
        #1;
        exp_valid = 1'b0; reg_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0; halt = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_ev(input ev_t e);
        for (int t = 0; t < 20; t++) begin
            exp_valid = 1'b1; exp_kind = e.k; exp_a = e.a; exp_d = e.d;
            tick();
            if (m_pushed) break;
        end
        chk("push_accepted", m_pushed, 1);
    endtask

    task automatic set_obs(input ev_t e);
        case (e.k)
            2'd0: begin reg_we = 1'b1; reg_id = e.a[3:0]; reg_data = e.d; end
            2'd1: begin mem_re = 1'b1; mem_addr = e.a; mem_rdata = e.d; end
            2'd2: begin mem_we = 1'b1; mem_addr = e.a; mem_wdata = e.d; end
            default: halt = 1'b1;
        endcase
    endtask

    task automatic rand_iter();
        ev_t tr[$];
        ev_t e;
        int  len, pi, oi, avail, want, g;
        bit  starve;
        do_reset();
        len = $urandom_range(1, 14);
        for (int i = 0; i < len - 1; i++)
            tr.push_back(mk(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom)));
        tr.push_back(mk(2'd3, 16'($urandom), 16'($urandom)));
        pi = 0; oi = 0;
        for (int c = 0; c < 300 && m_st == 0; c++) begin
            if (pi < len && $urandom_range(0, 1) == 1) begin
                exp_valid = 1'b1; exp_kind = tr[pi].k; exp_a = tr[pi].a; exp_d = tr[pi].d;
            end
            if (oi < len && $urandom_range(0, 2) != 0) begin
                avail  = q.size();
                want   = $urandom_range(1, 4);
                starve = ($urandom_range(0, 31) == 0);
                g = 0;
                if (avail > 0 || starve) begin
                    while (g < want && oi + g < len && (starve || g < avail) &&
                           (g == 0 || (tr[oi+g].k > tr[oi+g-1].k &&
                                       !(tr[oi+g-1].k == 2'd1 && tr[oi+g].k == 2'd2))))
                        g++;
                    for (int k = 0; k < g; k++) begin
                        e = tr[oi+k];
                        if (e.k != 2'd3 && $urandom_range(0, 19) == 0)
                            e.d = e.d ^ (16'd1 << $urandom_range(0, 15));
                        set_obs(e);
                    end
                    oi += g;
                end
            end
            tick();
            if (m_pushed) pi++;
        end
        chk("rnd_finished", done, 1);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_ready", exp_ready, 1);
        chk("rst_done", done, 0);

        // REG, STORE, HALT in separate cycles
        push_ev(mk(2'd0, 16'h0003, 16'h0005));
        push_ev(mk(2'd2, 16'h0010, 16'h0005));
        push_ev(mk(2'd3, 16'h0000, 16'h0000));
        set_obs(mk(2'd0, 16'h0003, 16'h0005)); tick();
        set_obs(mk(2'd2, 16'h0010, 16'h0005)); tick();
        set_obs(mk(2'd3, 16'h0000, 16'h0000)); tick();
        chk("t1_pass", pass, 1);
        chk("t1_code", err_code, 0);
        chk("t1_checked", events_checked, 3);

        // REG and STORE in the same cycle pop two entries at once
        do_reset();
        push_ev(mk(2'd0, 16'h0001, 16'h00AA));
        push_ev(mk(2'd2, 16'h0020, 16'h00BB));
        push_ev(mk(2'd3, 16'h0000, 16'h0000));
        set_obs(mk(2'd0, 16'h0001, 16'h00AA));
        set_obs(mk(2'd2, 16'h0020, 16'h00BB));
        tick();
        chk("t2_checked", events_checked, 2);
        set_obs(mk(2'd3, 16'h0000, 16'h0000)); tick();
        chk("t2_pass", pass, 1);

        // register data mismatch
        do_reset();
        push_ev(mk(2'd0, 16'h0002, 16'h1234));
        set_obs(mk(2'd0, 16'h0002, 16'h1235)); tick();
        chk("t3_code", err_code, 2);
        chk("t3_exp_d", err_exp_d, 16'h1234);
        chk("t3_got_d", err_got_d, 16'h1235);
`ifndef TRACE_CHK_CONTINUE_EN
        chk("t3_ready", exp_ready, 0);
        chk("t3_done", done, 1);
`endif

        // kind mismatch: expected LOAD, saw STORE
        do_reset();
        push_ev(mk(2'd1, 16'h0040, 16'h0007));
        set_obs(mk(2'd2, 16'h0040, 16'h0007)); tick();
        chk("t3k_code", err_code, 1);
        chk("t3k_got_a", err_got_a, 0);

        // starved: observation with an empty queue
        do_reset();
        set_obs(mk(2'd0, 16'h0001, 16'h0001)); tick();
        chk("t4_code", err_code, 3);
        chk("t4_done", done, 1);

        // leftover: HALT matched with two entries behind it
        do_reset();
        push_ev(mk(2'd3, 16'h0000, 16'h0000));
        push_ev(mk(2'd0, 16'h0001, 16'h0011));
        push_ev(mk(2'd0, 16'h0002, 16'h0022));
        set_obs(mk(2'd3, 16'h0000, 16'h0000)); tick();
        chk("t5_code", err_code, 4);
        chk("t5_pass", pass, 0);

        // FIFO full drops exp_ready
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ev(mk(2'd0, 16'(i), 16'(i * 3)));
        chk("full_ready", exp_ready, 0);

        // mid-run reset discards everything
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_ready", exp_ready, 1);
        chk("midrst_checked", events_checked, 0);

        // idle timeout
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) tick();
        chk("t6_code", err_code, 5);
        chk("t6_cycle", err_cycle, 49);

`ifdef TRACE_CHK_CONTINUE_EN
        // two data mismatches then a matched HALT
        do_reset();
        push_ev(mk(2'd0, 16'h0001, 16'h0001));
        push_ev(mk(2'd0, 16'h0002, 16'h0002));
        push_ev(mk(2'd3, 16'h0000, 16'h0000));
        set_obs(mk(2'd0, 16'h0001, 16'hFFFF)); tick();
        set_obs(mk(2'd0, 16'h0002, 16'h0000)); tick();
        set_obs(mk(2'd3, 16'h0000, 16'h0000)); tick();
        chk("c_done", done, 1);
        chk("c_pass", pass, 0);
        chk("c_errs", err_count, 2);
        chk("c_exp_d", err_exp_d, 16'h0001);
        chk("c_got_d", err_got_d, 16'hFFFF);
`endif

        // randomized traces
        for (int it = 0; it < 40; it++) rand_iter();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
Synthesizable golden-trace checker; the consuming end of the commit-trace stream the CPU bench produces (REG / LOAD / STORE / HALT events).
- Expected events are streamed in via a valid/ready interface and buffered.
- Each cycle, the DUT's live commit signals (writeback register write, memory-stage load/store, halt) are compared in order against buffered expected events.
- Latches pass/fail, first-mismatch details and counters.
- Placed beside the cpu top for FPGA self-check and for bench use.

Parameters:
DEPTH, 16, expected-event FIFO entries; power of 2, >=4
TIMEOUT, 1000, max RUN cycles with no observed event before FAIL; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
exp_valid  in  1  expected event offered
exp_ready  out  1  checker accepts expected event
exp_kind  in  2  0=REG 1=LOAD 2=STORE 3=HALT
exp_a  in  16  register id (bits 3:0) or memory address
exp_d  in  16  register write data or memory data
reg_we  in  1  writeback register write this cycle
reg_id  in  4  register written
reg_data  in  16  data written
mem_re  in  1  memory-stage load
mem_we  in  1  memory-stage store
mem_addr  in  16  memory address
mem_rdata  in  16  load data
mem_wdata  in  16  store data
halt  in  1  halt reached memory/writeback
done  out  1  checking finished (PASS or FAIL)
pass  out  1  trace matched through HALT
err_code  out  3  0 none, 1 kind mismatch, 2 addr/data mismatch, 3 starved, 4 leftover, 5 timeout
err_cycle  out  32  RUN cycle index of the first failure
err_exp_a, err_exp_d, err_got_a, err_got_d  out  16 each  operands of the first mismatch
events_checked  out  16  matched events, saturating

Behaviour:
Reset:
- FIFO empty. State RUN.
- All outputs 0, except exp_ready=1.
- Reset mid-operation discards everything.

FIFO and handshake:
- Push when exp_valid & exp_ready.
- exp_ready = state RUN & count<DEPTH, using the registered count.
- Push and pops in the same cycle are legal: count' = count + push − pops.
- A pushed entry is not visible for comparison until the next cycle.

Observed events per cycle:
- Ordered list: REG if reg_we, LOAD if mem_re, STORE if mem_we, HALT if halt. n_obs is 0..4.
- Observed i is compared with FIFO entry head+i.

Matching rules:
- Kind must be equal.
- REG: exp_a[3:0]==reg_id and exp_d==reg_data; exp_a[15:4] ignored.
- LOAD: addr and mem_rdata. STORE: addr and mem_wdata. HALT: a/d ignored.

Outcomes:
- n_obs>count → FAIL code 3. No compare that cycle.
- Any mismatch → FAIL with the code of the lowest-index mismatch; err_* capture that pair.
  - For HALT/kind mismatches, got_a/got_d are 0.
- All match → pop n_obs entries and add n_obs to events_checked.
  - If HALT matched: PASS if the FIFO is empty after the pop, else FAIL code 4.

States: RUN → PASS | FAIL, both terminal until reset. In PASS/FAIL:
- Inputs are ignored and outputs frozen.
- exp_ready=0.
- done=1. pass=1 only in PASS.

Counters:
- Cycle counter counts RUN cycles, 32-bit, saturating.
- Idle counter clears on any observed event. Reaching TIMEOUT → FAIL code 5.

Optional Feature:
TRACE_CHK_CONTINUE_EN defined:
- A mismatch does not enter FAIL. Mismatching entries are still popped.
- Adds output err_count[15:0] (saturating).
- err_* hold the first failure only.
- Codes 3/4/5 stay terminal.
- At HALT, done=1; pass=(err_count==0).

Undefined: first failure is terminal as above; no err_count port.

Decomposition:
trace_pkg holds:
- kind enum (KIND_REG..KIND_HALT)
- err code constants
- trace_evt_t struct {kind, a, d}

Sub-module trace_fifo:
- DEPTH entries.
- Combinational peek of head, head+1, head+2, head+3.
- Multi-pop 0..4 and single push per cycle; count output.

Test Plan:
- Push REG(r3,0x0005), STORE(0x0010,0x0005), HALT; drive reg_we r3/5, then mem_we 0x0010/5, then halt → pass=1, err_code=0, events_checked=3.
- Same cycle reg_we r1/0x00AA and mem_we 0x0020/0x00BB, expected REG then STORE queued → both popped in one cycle, count drops by 2.
- Expected REG r2 0x1234, DUT writes r2 0x1235 → FAIL, err_code=2, err_exp_d=0x1234, err_got_d=0x1235, exp_ready=0.
- Queue empty, DUT reg_we → err_code=3. Separately, HALT matched with 2 entries left → err_code=4.
- No events for TIMEOUT=50 cycles → err_code=5 at err_cycle=49. Assert rst_n=0 mid-run → all outputs 0, exp_ready=1 next cycle.
- With TRACE_CHK_CONTINUE_EN: 2 data mismatches then matched HALT → done=1, pass=0, err_count=2, err_* from the first mismatch.
